hif_queue_sched: RTL and testbench

Controller that sequences the high-frequency sample queue's 1536x16 dual-port RAM for the FIR stage. It generates write addresses for incoming samples, tracks fill level, and on each new sample (once primed) issues a burst of TAPS read addresses plus matching coefficient addresses and MAC strobes. It sits between the sample-valid edge detector and the queue RAM/MAC datapath and holds no sample data.

---
 rtl/hif_pkg.sv | 15 +
 rtl/hif_ptr_wrap.sv | 40 ++++
 rtl/hif_queue_sched.sv | 207 ++++++++++++++++++++
 tb/tb_hif_queue_sched.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hif_pkg.sv
// Shared constants and FSM state type for the high-frequency sample queue
// scheduler (hif_queue_sched and its pointer-wrap helper).
package hif_pkg;

    localparam int HIF_DEPTH = 1536;
    localparam int HIF_TAPS  = 1021;
    localparam int HIF_PTR_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } hif_sched_state_t;

endpackage

// File: rtl/hif_ptr_wrap.sv
// Modular pointer arithmetic on DEPTH: result = (ptr + k) mod DEPTH, or
// (ptr - k) mod DEPTH when sub is set. Both operands must already be below
// DEPTH (k may equal DEPTH-1 at most), so one conditional correction suffices.
module hif_ptr_wrap
    import hif_pkg::*;
#(
    parameter int DEPTH = HIF_DEPTH,
    parameter int PTR_W = HIF_PTR_W
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [PTR_W-1:0] k,
    input  logic             sub,
    output logic [PTR_W-1:0] result
);

    // One extra bit so ptr + k and ptr + DEPTH - k never overflow.
    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0] ptr_x;
    logic [PTR_W:0] k_x;
    logic [PTR_W:0] sum_x;
    logic [PTR_W:0] diff_x;

    // Wrap the sum or difference back into 0..DEPTH-1.
    always_comb begin
        ptr_x = {1'b0, ptr};
        k_x   = {1'b0, k};
        sum_x = ptr_x + k_x;
        if (sum_x >= DEPTH_X) begin
            sum_x = sum_x - DEPTH_X;
        end
        if (ptr_x >= k_x) begin
            diff_x = ptr_x - k_x;
        end else begin
            diff_x = ptr_x + DEPTH_X - k_x;
        end
        result = sub ? diff_x[PTR_W-1:0] : sum_x[PTR_W-1:0];
    end

endmodule

// File: rtl/hif_queue_sched.sv
// Queue RAM sequencer for the FIR stage: write addressing, fill tracking and
// burst read/coefficient addressing with MAC strobes.
// Optional feature macro: HIF_START_PEND_EN -- when defined, a start request
// arriving while a burst is busy is held in a 1-deep pending slot; otherwise
// such a request is dropped and flagged in overrun.
// Note: rst_n is an active-high synchronous reset despite its name.
// Read-side handshake: there is no back-pressure. raddr is valid while
// sequencing is high; the RAM returns rdata one cycle later, and mac_en /
// mac_clr / mac_last are aligned with that rdata, not with raddr.
module hif_queue_sched
    import hif_pkg::*;
#(
    parameter int DEPTH = HIF_DEPTH,
    parameter int TAPS  = HIF_TAPS,
    parameter int PTR_W = HIF_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_rise,
    output logic             wr_en,
    output logic [PTR_W-1:0] waddr,
    output logic [PTR_W-1:0] raddr,
    output logic [PTR_W-1:0] coeff_addr,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             mac_last,
    output logic             sequencing,
    output logic             primed,
    output logic             overrun,
    output hif_sched_state_t state_dbg
);

    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);
    localparam logic [PTR_W-1:0] TAPS_LAST = PTR_W'(TAPS - 1);
    localparam logic [PTR_W-1:0] TAPS_FULL = PTR_W'(TAPS);

    hif_sched_state_t state_q;
    hif_sched_state_t state_nxt;

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_inc;
    logic [PTR_W-1:0] fill_q;
    logic [PTR_W-1:0] raddr_q;
    logic [PTR_W-1:0] raddr_nxt;
    logic [PTR_W-1:0] raddr_inc;
    logic [PTR_W-1:0] coeff_q;
    logic [PTR_W-1:0] coeff_nxt;
    logic [PTR_W-1:0] start_addr;
    logic             start_req;
    logic             primed_w;
    logic             pend_q;
    logic [PTR_W-1:0] pend_addr_q;
    logic             lost_req;
    logic             ovr_q;
    logic             mac_en_q;
    logic             mac_clr_q;

    // Next write pointer.
    hif_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wptr_wrap (
        .ptr    (wptr_q),
        .k      (ONE),
        .sub    (1'b0),
        .result (wptr_inc)
    );

    // Next read address within a burst.
    hif_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_raddr_wrap (
        .ptr    (raddr_q),
        .k      (ONE),
        .sub    (1'b0),
        .result (raddr_inc)
    );

    // Oldest tap of the window whose newest tap is the sample being written.
    hif_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_start_wrap (
        .ptr    (wptr_q),
        .k      (TAPS_LAST),
        .sub    (1'b1),
        .result (start_addr)
    );

    assign primed_w  = (fill_q == TAPS_FULL);
    // The strobe that brings fill to TAPS already completes a full window.
    assign start_req = valid_rise && ((fill_q == TAPS_LAST) || primed_w);

    // Write pointer and saturating fill counter advance on every sample.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wptr_q <= '0;
            fill_q <= '0;
        end else if (valid_rise) begin
            wptr_q <= wptr_inc;
            if (fill_q != TAPS_FULL) begin
                fill_q <= fill_q + ONE;
            end
        end
    end

`ifdef HIF_START_PEND_EN
    logic pend_take;
    logic busy;

    // The slot frees in the cycle its request is launched into BURST, so a
    // request in that same cycle can refill it.
    assign pend_take = pend_q && ((state_q == IDLE) || (state_q == DRAIN));
    assign busy      = (state_q != IDLE) || pend_q;
    assign lost_req  = start_req && pend_q && !pend_take;

    // Pending start slot: capture a busy-time request with its start address.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else if (start_req && busy && (!pend_q || pend_take)) begin
            pend_q      <= 1'b1;
            pend_addr_q <= start_addr;
        end else if (pend_take) begin
            pend_q <= 1'b0;
        end
    end
`else
    assign pend_q      = 1'b0;
    assign pend_addr_q = '0;
    assign lost_req    = start_req && (state_q != IDLE);
`endif

    // Sticky overrun: any start request that could not be honoured.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ovr_q <= 1'b0;
        end else if (lost_req) begin
            ovr_q <= 1'b1;
        end
    end

    // Scheduler next state and read-side addressing.
    always_comb begin
        state_nxt = state_q;
        raddr_nxt = raddr_q;
        coeff_nxt = coeff_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_nxt = BURST;
                    raddr_nxt = pend_addr_q;
                    coeff_nxt = '0;
                end else if (start_req) begin
                    state_nxt = BURST;
                    raddr_nxt = start_addr;
                    coeff_nxt = '0;
                end
            end
            BURST: begin
                if (coeff_q == TAPS_LAST) begin
                    state_nxt = DRAIN;
                    coeff_nxt = '0;
                end else begin
                    raddr_nxt = raddr_inc;
                    coeff_nxt = coeff_q + ONE;
                end
            end
            DRAIN: begin
                if (pend_q) begin
                    state_nxt = BURST;
                    raddr_nxt = pend_addr_q;
                    coeff_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                coeff_nxt = '0;
            end
        endcase
    end

    // State register, read addresses and MAC strobes delayed by the RAM latency.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            coeff_q   <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            raddr_q   <= raddr_nxt;
            coeff_q   <= coeff_nxt;
            mac_en_q  <= (state_q == BURST);
            mac_clr_q <= (state_q == BURST) && (coeff_q == '0);
        end
    end

    assign wr_en      = valid_rise;
    assign waddr      = wptr_q;
    assign raddr      = raddr_q;
    assign coeff_addr = coeff_q;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign mac_last   = (state_q == DRAIN);
    assign sequencing = (state_q == BURST);
    assign primed     = primed_w;
    assign overrun    = ovr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_hif_queue_sched.sv
// Bench for hif_queue_sched: a small instance (DEPTH 16, TAPS 5) for the
// scenario and random tests and a default-size instance for the full burst.
// The reference model schedules bursts as time intervals on a cycle counter.
module tb_hif_queue_sched;
    import hif_pkg::*;

    localparam int SD = 16;
    localparam int ST = 5;
    localparam int SW = 4;

    typedef struct packed {
        logic        wr_en;
        logic        sequencing;
        logic        primed;
        logic        overrun;
        logic        mac_clr;
        logic        mac_en;
        logic        mac_last;
        logic [10:0] waddr;
        logic [10:0] raddr;
        logic [10:0] coeff;
    } obs_t;

    logic clk;
    logic rst_n;
    logic vr_s;
    logic vr_b;

    logic             s_wr_en, s_mac_clr, s_mac_en, s_mac_last, s_seq, s_primed, s_ovr;
    logic [SW-1:0]    s_waddr, s_raddr, s_coeff;
    hif_sched_state_t s_state;
    logic             b_wr_en, b_mac_clr, b_mac_en, b_mac_last, b_seq, b_primed, b_ovr;
    logic [10:0]      b_waddr, b_raddr, b_coeff;
    hif_sched_state_t b_state;

    int n_checks;
    int n_errors;

    // Reference model state
    int md;
    int mt;
    int cyc;
    int nsamp;
    int drain_d;
    int hold_ra;
    bit ovr;
    int bq_s[$];
    int bq_a[$];

    hif_queue_sched #(.DEPTH(SD), .TAPS(ST), .PTR_W(SW)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_rise (vr_s),
        .wr_en      (s_wr_en),
        .waddr      (s_waddr),
        .raddr      (s_raddr),
        .coeff_addr (s_coeff),
        .mac_clr    (s_mac_clr),
        .mac_en     (s_mac_en),
        .mac_last   (s_mac_last),
        .sequencing (s_seq),
        .primed     (s_primed),
        .overrun    (s_ovr),
        .state_dbg  (s_state)
    );

    hif_queue_sched dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_rise (vr_b),
        .wr_en      (b_wr_en),
        .waddr      (b_waddr),
        .raddr      (b_raddr),
        .coeff_addr (b_coeff),
        .mac_clr    (b_mac_clr),
        .mac_en     (b_mac_en),
        .mac_last   (b_mac_last),
        .sequencing (b_seq),
        .primed     (b_primed),
        .overrun    (b_ovr),
        .state_dbg  (b_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_small();
        obs_t o;
        o = '0;
        o.wr_en = s_wr_en; o.sequencing = s_seq; o.primed = s_primed; o.overrun = s_ovr;
        o.mac_clr = s_mac_clr; o.mac_en = s_mac_en; o.mac_last = s_mac_last;
        o.waddr = 11'(s_waddr); o.raddr = 11'(s_raddr); o.coeff = 11'(s_coeff);
        return o;
    endfunction

    function automatic obs_t obs_big();
        obs_t o;
        o = '0;
        o.wr_en = b_wr_en; o.sequencing = b_seq; o.primed = b_primed; o.overrun = b_ovr;
        o.mac_clr = b_mac_clr; o.mac_en = b_mac_en; o.mac_last = b_mac_last;
        o.waddr = b_waddr; o.raddr = b_raddr; o.coeff = b_coeff;
        return o;
    endfunction

    function automatic void model_reset();
        nsamp   = 0;
        drain_d = -1000;
        hold_ra = 0;
        ovr     = 1'b0;
        bq_s.delete();
        bq_a.delete();
    endfunction

    // A burst started at cycle s sequences s..s+mt-1 and drains at s+mt.
    function automatic void model_request(int t, int a);
`ifdef HIF_START_PEND_EN
        int last_s;
        int s;
        last_s = (bq_s.size() > 0) ? bq_s[bq_s.size()-1] : -1000;
        if (last_s > t + 1) begin
            ovr = 1'b1;
        end else begin
            if (t > drain_d) s = t + 1;
            else if (t < drain_d) s = drain_d + 1;
            else s = drain_d + 2;
            bq_s.push_back(s);
            bq_a.push_back(a);
            drain_d = s + mt;
        end
`else
        if (t > drain_d) begin
            bq_s.push_back(t + 1);
            bq_a.push_back(a);
            drain_d = t + 1 + mt;
        end else begin
            ovr = 1'b1;
        end
`endif
    endfunction

    function automatic obs_t model_expect(bit vr);
        obs_t e;
        int s;
        int a;
        e = '0;
        e.wr_en   = vr;
        e.waddr   = 11'(nsamp % md);
        e.primed  = (nsamp >= mt);
        e.overrun = ovr;
        e.raddr   = 11'(hold_ra);
        for (int i = 0; i < bq_s.size(); i++) begin
            s = bq_s[i];
            a = bq_a[i];
            if (cyc >= s && cyc <= s + mt - 1) begin
                e.sequencing = 1'b1;
                e.raddr = 11'((a + cyc - s) % md);
                e.coeff = 11'(cyc - s);
            end else if (cyc >= s + mt) begin
                e.raddr = 11'((a + mt - 1) % md);
            end
            if (cyc >= s + 1 && cyc <= s + mt) e.mac_en = 1'b1;
            if (cyc == s + 1) e.mac_clr = 1'b1;
            if (cyc == s + mt) e.mac_last = 1'b1;
        end
        return e;
    endfunction

    // Driver: take the clock edge and advance the model by one cycle.
    task automatic adv(input bit vr);
        int wa;
        @(posedge clk);
        if (rst_n) begin
            model_reset();
        end else if (vr) begin
            wa = nsamp % md;
            nsamp++;
            if (nsamp >= mt) model_request(cyc, (wa - (mt - 1) + md) % md);
        end
        cyc++;
        while (bq_s.size() > 0 && bq_s[0] + mt < cyc) begin
            hold_ra = (bq_a[0] + mt - 1) % md;
            void'(bq_s.pop_front());
            void'(bq_a.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b1;
        vr_s  = 1'b0;
        vr_b  = 1'b0;
        adv(1'b0);
        adv(1'b0);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        obs_t g;
        md = SD; mt = ST;
        apply_reset();
        #1;
        g = obs_small();
        n_checks++;
        if (g !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL reset_small got=%h exp=0", g);
        end
        g = obs_big();
        n_checks++;
        if (g !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL reset_big got=%h exp=0", g);
        end
        n_checks++;
        if (s_state !== IDLE || b_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state got=%0d/%0d exp=%0d", s_state, b_state, IDLE);
        end
    endtask

    task automatic test_prime();
        bit   pv[$];
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 2)) pv.push_back(1'b0);
            pv.push_back(1'b1);
        end
        repeat (9) pv.push_back(1'b0);
        foreach (pv[i]) begin
            vr_s = pv[i];
            #1;
            e = model_expect(pv[i]);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL prime cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(pv[i]);
        end
        vr_s = 1'b0;
    endtask

    task automatic test_wrap();
        bit   pv[$];
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        for (int k = 0; k < 19; k++) begin
            pv.push_back(1'b1);
            repeat (7) pv.push_back(1'b0);
        end
        foreach (pv[i]) begin
            vr_s = pv[i];
            #1;
            e = model_expect(pv[i]);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(pv[i]);
        end
        vr_s = 1'b0;
    endtask

    task automatic test_pending();
        bit   pv[$];
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        repeat (4) begin
            pv.push_back(1'b1);
            pv.push_back(1'b0);
        end
        pv.push_back(1'b1);
        pv.push_back(1'b0);
        pv.push_back(1'b0);
        pv.push_back(1'b1);
        repeat (16) pv.push_back(1'b0);
        foreach (pv[i]) begin
            vr_s = pv[i];
            #1;
            e = model_expect(pv[i]);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL pending cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(pv[i]);
        end
        vr_s = 1'b0;
    endtask

    task automatic test_overrun();
        bit   pv[$];
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        repeat (4) pv.push_back(1'b1);
        pv.push_back(1'b0);
        pv.push_back(1'b1);
        pv.push_back(1'b0);
        pv.push_back(1'b1);
        pv.push_back(1'b1);
        repeat (30) pv.push_back(1'b0);
        foreach (pv[i]) begin
            vr_s = pv[i];
            #1;
            e = model_expect(pv[i]);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL overrun cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(pv[i]);
        end
        vr_s = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bit   pv[$];
        bit   pr[$];
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        repeat (5) begin pv.push_back(1'b1); pr.push_back(1'b0); pv.push_back(1'b0); pr.push_back(1'b0); end
        pv.push_back(1'b0); pr.push_back(1'b0);
        pv.push_back(1'b0); pr.push_back(1'b1);
        repeat (5) begin pv.push_back(1'b1); pr.push_back(1'b0); pv.push_back(1'b0); pr.push_back(1'b0); end
        repeat (8) begin pv.push_back(1'b0); pr.push_back(1'b0); end
        foreach (pv[i]) begin
            rst_n = pr[i];
            vr_s  = pv[i];
            #1;
            e = model_expect(pv[i]);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(pv[i]);
        end
        rst_n = 1'b0;
        vr_s  = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            vr_s = (i < 40);
            #1;
            e = model_expect(vr_s);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(vr_s);
        end
        vr_s = 1'b0;
    endtask

    task automatic test_random();
        bit   r;
        bit   v;
        obs_t e, g;
        md = SD; mt = ST;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = r ? 1'b0 : ($urandom_range(0, 3) == 0);
            rst_n = r;
            vr_s  = v;
            #1;
            e = model_expect(v);
            g = obs_small();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            adv(v);
        end
        rst_n = 1'b0;
        vr_s  = 1'b0;
    endtask

    task automatic test_default();
        obs_t e, g;
        int   trig;
        int   seq_cnt;
        int   en_cnt;
        int   last_rel;
        int   first_ra;
        md = HIF_DEPTH; mt = HIF_TAPS;
        apply_reset();
        trig = -1; seq_cnt = 0; en_cnt = 0; last_rel = -1; first_ra = -1;
        for (int i = 0; i < HIF_TAPS + HIF_TAPS + 8; i++) begin
            vr_b = (i < HIF_TAPS);
            if (i == HIF_TAPS - 1) trig = cyc;
            #1;
            e = model_expect(vr_b);
            g = obs_big();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL default cyc=%0d got=%h exp=%h", cyc, g, e);
            end
            if (b_seq === 1'b1) begin
                if (seq_cnt == 0) first_ra = int'(b_raddr);
                seq_cnt++;
            end
            if (b_mac_en === 1'b1) en_cnt++;
            if (b_mac_last === 1'b1 && trig >= 0) last_rel = cyc - trig;
            adv(vr_b);
        end
        vr_b = 1'b0;
        n_checks++;
        if (seq_cnt != HIF_TAPS) begin
            n_errors++;
            $display("FAIL default_seq_len got=%0d exp=%0d", seq_cnt, HIF_TAPS);
        end
        n_checks++;
        if (en_cnt != HIF_TAPS) begin
            n_errors++;
            $display("FAIL default_mac_en_len got=%0d exp=%0d", en_cnt, HIF_TAPS);
        end
        n_checks++;
        if (first_ra != 0) begin
            n_errors++;
            $display("FAIL default_first_raddr got=%0d exp=0", first_ra);
        end
        n_checks++;
        if (last_rel != HIF_TAPS + 1) begin
            n_errors++;
            $display("FAIL default_mac_last got=T+%0d exp=T+%0d", last_rel, HIF_TAPS + 1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        md       = SD;
        mt       = ST;
        rst_n    = 1'b1;
        vr_s     = 1'b0;
        vr_b     = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_prime();
        test_wrap();
        test_pending();
        test_overrun();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
